// File: rtl/axi_slv_pkg.sv
// Shared AXI encodings, FSM state types and burst/response helpers
// for the AIU AXI slave memory.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

  // Whole-burst response decided at address acceptance.
  function automatic resp_e check_req(input logic [31:0] addr, input logic [7:0] len,
                                      input burst_e burst, input logic [31:0] mem_bytes);
    if (addr >= mem_bytes) return RESP_DECERR;
    if (burst == BURST_FIXED || burst == BURST_RSVD) return RESP_SLVERR;
    if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Encodings are ordered so the numerically larger response is the worse one.
  function automatic resp_e worst_resp(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

  // Word index of a beat; WRAP lengths are 2^n-1 so len doubles as the window mask.
  function automatic logic [31:0] beat_word(input logic [31:0] start, input logic [7:0] len,
                                            input burst_e burst, input logic [7:0] beat);
    if (burst == BURST_WRAP)
      return (start & ~{24'd0, len}) | ((start + {24'd0, beat}) & {24'd0, len});
    return start + {24'd0, beat};
  endfunction

endpackage

// File: rtl/axi_slv_ram.sv
// Byte-enabled single-clock storage with registered, write-first read port.
module axi_slv_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W/8-1:0]        i_wstrb,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W-1:0]          o_rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_rd_word;

  // Bypass the bytes being written this cycle so a colliding read sees new data.
  always_comb begin
    w_rd_word = r_mem[i_raddr];
    if (i_we && i_waddr == i_raddr) begin
      for (int b = 0; b < STRB_W; b++)
        if (i_wstrb[b]) w_rd_word[b*8 +: 8] = i_wdata[b*8 +: 8];
    end
  end

  // NOTE: the storage array is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++)
      if (i_we && i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= w_rd_word;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/aiu_axi_slv_mem.sv
// AXI slave memory responder: one outstanding read and one outstanding write,
// independent read/write FSMs sharing a write-first storage block.
module aiu_axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 8);
  localparam logic [3:0]  LAT_LAST  = 4'(RD_LAT - 2);

  // ---------------- read channel ----------------
  rd_state_e         r_rd_state, w_rd_next;
  logic [ID_W-1:0]   r_ar_id;
  logic [31:0]       r_ar_start;
  logic [7:0]        r_ar_len, r_rd_beat;
  burst_e            r_ar_burst;
  resp_e             r_ar_resp;
  logic [3:0]        r_lat_cnt;

  logic              w_rd_fetch, w_rd_re, w_rd_last, w_rd_idle;
  resp_e             w_ar_resp_new, w_f_resp;
  logic [31:0]       w_f_start;
  logic [7:0]        w_f_len, w_f_beat;
  burst_e            w_f_burst;
  logic [IDX_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_rd_last     = (r_rd_beat == r_ar_len);
  assign w_rd_idle     = (r_rd_state == RD_IDLE);
  assign w_ar_resp_new = check_req(araddr, arlen, burst_e'(arburst), MEM_BYTES);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_rd_next  = r_rd_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    w_rd_fetch = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          if (RD_LAT == 1) begin
            w_rd_next  = RD_BURST;
            w_rd_fetch = 1'b1;
          end else begin
            w_rd_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_rd_next  = RD_BURST;
          w_rd_fetch = 1'b1;
        end
      end
      RD_BURST: begin
        rvalid = 1'b1;
        if (rready) begin
          if (w_rd_last) w_rd_next  = RD_IDLE;
          else           w_rd_fetch = 1'b1;
        end
      end
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // The fetch for the next beat happens on the edge before it is presented.
  assign w_f_start = w_rd_idle ? {3'b000, araddr[31:3]} : r_ar_start;
  assign w_f_len   = w_rd_idle ? arlen : r_ar_len;
  assign w_f_burst = w_rd_idle ? burst_e'(arburst) : r_ar_burst;
  assign w_f_resp  = w_rd_idle ? w_ar_resp_new : r_ar_resp;
  assign w_f_beat  = (r_rd_state == RD_BURST) ? r_rd_beat + 8'd1 : 8'd0;
  assign w_rd_re   = w_rd_fetch && (w_f_resp == RESP_OKAY);
  assign w_rd_addr = IDX_W'(beat_word(w_f_start, w_f_len, w_f_burst, w_f_beat));

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_rd_state <= RD_IDLE;
    else     r_rd_state <= w_rd_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_id    <= '0;
      r_ar_start <= '0;
      r_ar_len   <= '0;
      r_ar_burst <= BURST_FIXED;
      r_ar_resp  <= RESP_OKAY;
      r_lat_cnt  <= '0;
      r_rd_beat  <= '0;
    end else if (arvalid && arready) begin
      r_ar_id    <= arid;
      r_ar_start <= w_f_start;
      r_ar_len   <= arlen;
      r_ar_burst <= burst_e'(arburst);
      r_ar_resp  <= w_ar_resp_new;
      r_lat_cnt  <= '0;
      r_rd_beat  <= '0;
    end else begin
      if (r_rd_state == RD_WAIT) r_lat_cnt <= r_lat_cnt + 4'd1;
      if (rvalid && rready)      r_rd_beat <= r_rd_beat + 8'd1;
    end
  end

  assign rid   = r_ar_id;
  assign rlast = (r_rd_state == RD_BURST) && w_rd_last;
  assign rresp = (r_rd_state == RD_BURST) ? r_ar_resp : RESP_OKAY;
  assign rdata = (r_rd_state == RD_BURST && r_ar_resp == RESP_OKAY) ? w_ram_rdata : '0;

  // ---------------- write channel ----------------
  wr_state_e         r_wr_state, w_wr_next;
  logic [ID_W-1:0]   r_aw_id;
  logic [31:0]       r_aw_start;
  logic [7:0]        r_aw_len, r_wr_beat;
  burst_e            r_aw_burst;
  resp_e             r_aw_resp;

  logic              w_wr_end, w_len_err, w_we;
  logic [IDX_W-1:0]  w_wr_addr;

  // Exit on wlast or on the final expected beat, whichever comes first.
  assign w_wr_end  = wlast || (r_wr_beat == r_aw_len);
  assign w_len_err = wlast != (r_wr_beat == r_aw_len);
  assign w_we      = wvalid && wready && (r_aw_resp == RESP_OKAY);
  assign w_wr_addr = IDX_W'(beat_word(r_aw_start, r_aw_len, r_aw_burst, r_wr_beat));

  always_comb begin
    w_wr_next = r_wr_state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_wr_next = WR_DATA;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && w_wr_end) w_wr_next = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) w_wr_next = WR_IDLE;
      end
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_wr_state <= WR_IDLE;
    else     r_wr_state <= w_wr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_id    <= '0;
      r_aw_start <= '0;
      r_aw_len   <= '0;
      r_aw_burst <= BURST_FIXED;
      r_aw_resp  <= RESP_OKAY;
      r_wr_beat  <= '0;
    end else if (awvalid && awready) begin
      r_aw_id    <= awid;
      r_aw_start <= {3'b000, awaddr[31:3]};
      r_aw_len   <= awlen;
      r_aw_burst <= burst_e'(awburst);
      r_aw_resp  <= check_req(awaddr, awlen, burst_e'(awburst), MEM_BYTES);
      r_wr_beat  <= '0;
    end else if (wvalid && wready) begin
      r_wr_beat <= r_wr_beat + 8'd1;
      if (w_wr_end && w_len_err) r_aw_resp <= worst_resp(r_aw_resp, RESP_SLVERR);
    end
  end

  assign bid   = r_aw_id;
  assign bresp = (r_wr_state == WR_RESP) ? r_aw_resp : RESP_OKAY;

  axi_slv_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wstrb (wstrb),
    .i_wdata (wdata),
    .i_re    (w_rd_re),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_aiu_axi_slv_mem.sv
// Randomized self-checking bench for aiu_axi_slv_mem against a word-array
// reference model of AXI burst addressing and response rules.
module tb_aiu_axi_slv_mem;

  localparam int RD_LAT = 2;
  localparam int NWORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model [NWORDS];

  always #5 clk = ~clk;

  aiu_axi_slv_mem #(
    .ID_W(4), .DATA_W(64), .DEPTH(NWORDS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Word touched by a beat, straight from the burst definitions.
  function automatic int word_of(input int sw, input int len, input int burst, input int beat);
    int n, base;
    if (burst == 2) begin
      n    = len + 1;
      base = (sw / n) * n;
      return base + ((sw - base + beat) % n);
    end
    return (sw + beat) % NWORDS;
  endfunction

  function automatic int exp_resp(input logic [31:0] addr, input int len, input int burst);
    if (addr >= 32'(NWORDS * 8)) return 3;
    if (burst == 0 || burst == 3) return 2;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input int burst, input int wl_beat, input bit use_f,
                        input logic [63:0] fdata, input bit rnd_strb, input int bdly);
    int r, fin, nbeats, sw, cnt, w;
    logic [63:0] d;
    logic [7:0]  s;
    r  = exp_resp(addr, len, burst);
    sw = int'(addr >> 3);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awburst = 2'(burst);
    cnt = 0;
    while (!awready && cnt < 50) begin tick(); cnt++; end
    check("aw_ready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    nbeats = ((wl_beat < len) ? wl_beat : len) + 1;
    for (int i = 0; i < nbeats; i++) begin
      d = use_f ? fdata : {$urandom, $urandom};
      s = rnd_strb ? 8'($urandom) : 8'hFF;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = (i == wl_beat);
      cnt = 0;
      while (!wready && cnt < 50) begin tick(); cnt++; end
      check("w_ready", 64'(wready), 64'd1);
      if (r == 0) begin
        w = word_of(sw, len, burst, i);
        for (int b = 0; b < 8; b++)
          if (s[b]) model[w][b*8 +: 8] = d[b*8 +: 8];
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    fin = (wl_beat != len) ? ((r > 2) ? r : 2) : r;
    bready = 1'b0;
    cnt = 0;
    while (!bvalid && cnt < 50) begin tick(); cnt++; end
    check("b_valid", 64'(bvalid), 64'd1);
    for (int k = 0; k < bdly; k++) begin
      tick();
      check("b_hold", 64'(bvalid), 64'd1);
    end
    check("bresp", 64'(bresp), 64'(fin));
    check("bid", 64'(bid), 64'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done", 64'(bvalid), 64'd0);
  endtask

  // mode 0: rready always 1, 1: toggling 1/0, 2: random
  task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input int len,
                        input int burst, input int mode);
    int r, sw, cyc, beat, guard;
    bit tog;
    logic [63:0] e;
    r  = exp_resp(addr, len, burst);
    sw = int'(addr >> 3);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arburst = 2'(burst);
    cyc = 0;
    while (!arready && cyc < 50) begin tick(); cyc++; end
    check("ar_ready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    cyc = 1;
    while (!rvalid && cyc < 40) begin tick(); cyc++; end
    check("rd_lat", 64'(cyc), 64'(RD_LAT));
    beat = 0; guard = 0; tog = 1'b1;
    while (beat <= len && guard < 1000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       begin rready = tog; tog = !tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      e = (r == 0) ? model[word_of(sw, len, burst, beat)] : 64'd0;
      check("rvalid", 64'(rvalid), 64'd1);
      check("rdata", rdata, e);
      check("rid", 64'(rid), 64'(id));
      check("rlast", 64'(rlast), 64'(beat == len));
      check("rresp", 64'(rresp), 64'(r));
      tick();
      if (rready) beat++;
      guard++;
    end
    rready = 1'b0;
    check("r_idle", 64'(rvalid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, burst, len, wl;
    logic [31:0] addr;
    logic [63:0] nd;

    rst = 1'b1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    repeat (3) tick();

    check("rst_arready", 64'(arready), 64'd1);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rid",     64'(rid),     64'd0);
    check("rst_bid",     64'(bid),     64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_rdata",   rdata,        64'd0);
    rst = 1'b0;
    tick();

    // Fill all storage so the model is fully defined.
    axi_wr(4'h1, 32'h0, 255, 1, 255, 1'b0, 64'd0, 1'b0, 0);

    axi_wr(4'h2, 32'h40, 0, 1, 0, 1'b1, 64'h1122334455667788, 1'b0, 1);
    axi_rd(4'h3, 32'h40, 0, 1, 0);

    axi_rd(4'h4, 32'h18, 3, 2, 1);

    // Early wlast, then missing wlast.
    axi_wr(4'h5, 32'h80, 1, 1, 0, 1'b0, 64'd0, 1'b0, 3);
    axi_wr(4'h6, 32'h100, 2, 1, 9, 1'b0, 64'd0, 1'b0, 0);

    axi_rd(4'h7, 32'h800, 3, 1, 2);
    axi_wr(4'h8, 32'h100, 3, 0, 3, 1'b0, 64'd0, 1'b0, 1);
    axi_rd(4'h9, 32'h100, 3, 1, 0);
    axi_rd(4'hC, 32'h20, 2, 2, 0);
    axi_rd(4'hD, 32'h40, 0, 0, 0);

    // The W beat lands on the edge where the first read beat is fetched.
    nd = {$urandom, $urandom};
    awvalid = 1'b1; awid = 4'hA; awaddr = 32'h200; awlen = 8'd0; awburst = 2'd1;
    tick();
    awvalid = 1'b0;
    arvalid = 1'b1; arid = 4'hB; araddr = 32'h200; arlen = 8'd0; arburst = 2'd1;
    check("coll_arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    repeat (RD_LAT - 2) tick();
    wvalid = 1'b1; wdata = nd; wstrb = 8'h0F; wlast = 1'b1;
    check("coll_wready", 64'(wready), 64'd1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    model[64][31:0] = nd[31:0];
    check("coll_rvalid", 64'(rvalid), 64'd1);
    check("coll_rdata", rdata, model[64]);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("coll_bvalid", 64'(bvalid), 64'd1);
    check("coll_bresp", 64'(bresp), 64'd0);
    check("coll_bid", 64'(bid), 64'hA);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Reset in the middle of a read burst.
    arvalid = 1'b1; arid = 4'h3; araddr = 32'h0; arlen = 8'd7; arburst = 2'd1;
    tick();
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 40) begin tick(); cyc++; end
    check("mid_rvalid", 64'(rvalid), 64'd1);
    rready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_arready", 64'(arready), 64'd1);
    check("mid_rst_rlast", 64'(rlast), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_rst_quiet", 64'(rvalid), 64'd0);
    end
    rready = 1'b0;
    axi_rd(4'h2, 32'h0, 7, 1, 2);

    for (int it = 0; it < 30; it++) begin
      burst = $urandom_range(0, 9);
      burst = (burst < 7) ? 1 : (burst < 9) ? 2 : 0;
      if (burst == 2) begin
        case ($urandom_range(0, 7))
          0: len = 2;
          1, 2: len = 1;
          3, 4: len = 3;
          5, 6: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 9) == 0) addr = 32'h800 + 32'(8 * $urandom_range(0, 100));
      else                           addr = 32'(8 * $urandom_range(0, NWORDS - 1));
      wl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len + 1) : len;
      axi_wr(4'($urandom), addr, len, burst, wl, 1'b0, 64'd0, 1'b1, $urandom_range(0, 3));
      axi_rd(4'($urandom), addr, len, burst, $urandom_range(0, 2));
      axi_rd(4'($urandom), 32'(8 * $urandom_range(0, NWORDS - 1)), $urandom_range(0, 7), 1,
             $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
